// File: rtl/uart_rx_param.sv
// -----------------------------------------------------------------------------
// uart_rx_param
//
// Parameterised UART receiver with a one-word holding register and a
// valid/ready output port.
//
// Parameters
//   DATA_W        data bits per frame (5..9)
//   CLKS_PER_BIT  clk_i cycles per serial bit (>= 4)
//   PARITY        0 none, 1 even, 2 odd
//   STOP_BITS     1 or 2
//
// Ports
//   clk_i         clock, all logic on the rising edge
//   rst_ni        asynchronous active-low reset
//   rxd_i         asynchronous serial input, idle high
//   m_data_o      received word, LSB is the first data bit on the line
//   m_valid_o     m_data_o holds a word not yet taken by the consumer
//   m_ready_i     consumer ready
//   parity_err_o  one-cycle pulse: parity mismatch, word discarded
//   frame_err_o   one-cycle pulse: a stop bit sampled low, word discarded
//   overrun_o     one-cycle pulse: good word dropped, holding register full
//   busy_o        receiver is in any state other than IDLE
//   state_o       debug view of the receiver state (state_t encoding)
//
// Output handshake: a word is transferred in every cycle where
// m_valid_o & m_ready_i are both high at the rising edge. Once m_valid_o is
// high, m_data_o and m_valid_o stay unchanged until that transfer happens;
// a newly received word can replace the held one only in the transfer cycle.
// Reception never waits for m_ready_i; a word that finds the register still
// occupied is dropped and reported on overrun_o.
// -----------------------------------------------------------------------------
module uart_rx_param #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 104,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              rxd_i,
    output logic [DATA_W-1:0] m_data_o,
    output logic              m_valid_o,
    input  logic              m_ready_i,
    output logic              parity_err_o,
    output logic              frame_err_o,
    output logic              overrun_o,
    output logic              busy_o,
    output logic [2:0]        state_o
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START     = 3'd1,
        S_DATA      = 3'd2,
        S_PARITY    = 3'd3,
        S_STOP      = 3'd4,
        S_WAIT_HIGH = 3'd5
    } state_t;

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_W);

    // The start bit is checked half a bit after the falling edge is seen;
    // every later sample is a full bit period after the previous one.
    localparam logic [CNT_W-1:0] HALF_M1  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_M1   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);

    state_t             state;
    logic [1:0]         sync_q;
    logic [CNT_W-1:0]   cnt;
    logic [BIT_W-1:0]   bit_idx;
    logic               stop_idx;
    logic [DATA_W-1:0]  shreg;
    logic               par_bad;
    logic               frame_bad;
    logic               armed;

    logic               rx;
    logic               sample;
    logic               last_stop;
    logic               par_mismatch;

    assign rx     = sync_q[1];
    assign sample = (cnt == '0);

    always_comb begin
        last_stop = 1'b1;
        if (STOP_BITS == 2) begin
            last_stop = stop_idx;
        end
    end

    // XOR of all data bits and the received parity bit: 0 for a correct
    // even-parity frame, 1 for a correct odd-parity frame.
    always_comb begin
        par_mismatch = (^shreg) ^ rx;
        if (PARITY == 2) begin
            par_mismatch = ~((^shreg) ^ rx);
        end
    end

    assign busy_o  = (state != S_IDLE);
    assign state_o = state;

    // Two-flop synchronizer; it resets to the idle level so reset release
    // never looks like a start bit by itself.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rxd_i};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state        <= S_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            stop_idx     <= 1'b0;
            shreg        <= '0;
            par_bad      <= 1'b0;
            frame_bad    <= 1'b0;
            armed        <= 1'b0;
            m_data_o     <= '0;
            m_valid_o    <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;

            // Transfer without a simultaneous delivery empties the register;
            // a delivery below in the same cycle overrides this.
            if (m_valid_o && m_ready_i) begin
                m_valid_o <= 1'b0;
            end

            case (state)
                S_IDLE: begin
                    // armed is cleared by reset and set once the line has
                    // been seen high, so a line that is still low from a
                    // frame cut off by reset cannot start a bogus frame.
                    if (rx) begin
                        armed <= 1'b1;
                    end else if (armed) begin
                        state <= S_START;
                        cnt   <= HALF_M1;
                    end
                end

                S_START: begin
                    if (sample) begin
                        if (rx) begin
                            // Low pulse shorter than half a bit: ignore it.
                            state <= S_IDLE;
                        end else begin
                            state   <= S_DATA;
                            cnt     <= BIT_M1;
                            bit_idx <= '0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_DATA: begin
                    if (sample) begin
                        // Shift in at the top so the first bit ends up in
                        // bit 0 after DATA_W samples.
                        shreg <= {rx, shreg[DATA_W-1:1]};
                        cnt   <= BIT_M1;
                        if (bit_idx == BIT_LAST) begin
                            stop_idx  <= 1'b0;
                            par_bad   <= 1'b0;
                            frame_bad <= 1'b0;
                            if (PARITY != 0) begin
                                state <= S_PARITY;
                            end else begin
                                state <= S_STOP;
                            end
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_PARITY: begin
                    if (sample) begin
                        par_bad <= par_mismatch;
                        state   <= S_STOP;
                        cnt     <= BIT_M1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_STOP: begin
                    if (sample) begin
                        cnt <= BIT_M1;
                        if (!last_stop) begin
                            stop_idx  <= 1'b1;
                            frame_bad <= frame_bad | ~rx;
                        end else if (frame_bad || !rx) begin
                            // A low stop bit may be the start of a break;
                            // wait for the line to return high first.
                            frame_err_o <= 1'b1;
                            state       <= S_WAIT_HIGH;
                        end else if (par_bad) begin
                            parity_err_o <= 1'b1;
                            state        <= S_IDLE;
                        end else begin
                            state <= S_IDLE;
                            if (!m_valid_o || m_ready_i) begin
                                m_data_o  <= shreg;
                                m_valid_o <= 1'b1;
                            end else begin
                                overrun_o <= 1'b1;
                            end
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                S_WAIT_HIGH: begin
                    if (rx) begin
                        state <= S_IDLE;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_param.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_param
//
// Three receivers share one clock and reset:
//   id 0: 8 data bits, no parity, 1 stop bit
//   id 1: 8 data bits, even parity, 1 stop bit
//   id 2: 5 data bits, odd parity, 2 stop bits
// all with CLKS_PER_BIT = 4. Only one line is exercised at a time; every
// expected event (word presented, parity error, frame error, overrun) is
// pushed to exp_q as the frame is issued and popped by the monitor when the
// matching DUT output appears.
//
// Event encoding: {id[1:0], kind[1:0], data[8:0]}; kind 0 word, 1 parity
// error, 2 frame error, 3 overrun.
// -----------------------------------------------------------------------------
module tb_uart_rx_param;

    localparam int CPB = 4;
    localparam int W   = 13;

    logic       clk;
    logic       rst_n;
    logic       rxd   [3];
    logic       rdy   [3];
    logic       valid [3];
    logic       pe    [3];
    logic       fe    [3];
    logic       ov    [3];
    logic       busy  [3];
    logic [2:0] st    [3];
    logic [7:0] data_a;
    logic [7:0] data_b;
    logic [4:0] data_c;
    logic [8:0] od    [3];

    logic [W-1:0] exp_q[$];
    bit           model_full [3];
    int           checks;
    int           passed;

    logic       pv  [3];
    logic       phs [3];
    logic [8:0] pd  [3];

    // ---------------------------------------------------------------- DUTs
    uart_rx_param #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u_a (
        .clk_i(clk), .rst_ni(rst_n), .rxd_i(rxd[0]),
        .m_data_o(data_a), .m_valid_o(valid[0]), .m_ready_i(rdy[0]),
        .parity_err_o(pe[0]), .frame_err_o(fe[0]), .overrun_o(ov[0]),
        .busy_o(busy[0]), .state_o(st[0])
    );

    uart_rx_param #(.DATA_W(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u_b (
        .clk_i(clk), .rst_ni(rst_n), .rxd_i(rxd[1]),
        .m_data_o(data_b), .m_valid_o(valid[1]), .m_ready_i(rdy[1]),
        .parity_err_o(pe[1]), .frame_err_o(fe[1]), .overrun_o(ov[1]),
        .busy_o(busy[1]), .state_o(st[1])
    );

    uart_rx_param #(.DATA_W(5), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(2)) u_c (
        .clk_i(clk), .rst_ni(rst_n), .rxd_i(rxd[2]),
        .m_data_o(data_c), .m_valid_o(valid[2]), .m_ready_i(rdy[2]),
        .parity_err_o(pe[2]), .frame_err_o(fe[2]), .overrun_o(ov[2]),
        .busy_o(busy[2]), .state_o(st[2])
    );

    always_comb begin
        od[0] = {1'b0, data_a};
        od[1] = {1'b0, data_b};
        od[2] = {4'b0, data_c};
    end

    // -------------------------------------------------------- clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ------------------------------------------------------------- helpers
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic logic [W-1:0] evt(input int id, input int kind, input logic [8:0] d);
        logic [1:0] i2;
        logic [1:0] k2;
        i2 = id[1:0];
        k2 = kind[1:0];
        return {i2, k2, d};
    endfunction

    function automatic int data_bits(input int id);
        return (id == 2) ? 5 : 8;
    endfunction

    // ----------------------------------------------------------- scoreboard
    task automatic check_evt(input logic [W-1:0] got, input string what);
        logic [W-1:0] e;
        checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: got event %h expected none", what, got);
        end else begin
            e = exp_q.pop_front();
            if (e === got) passed++;
            else $display("FAIL %s: got event %h expected %h", what, got, e);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) begin
                pv[i]  <= 1'b0;
                phs[i] <= 1'b0;
                pd[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                int n;
                n = int'(pe[i]) + int'(fe[i]) + int'(ov[i]);
                if (n != 0) begin
                    checks++;
                    if (n == 1) passed++;
                    else $display("FAIL flags_onehot[%0d]: got %0d pulses expected 1", i, n);
                end
                if (pe[i]) check_evt(evt(i, 1, 9'h0), "parity_err");
                if (fe[i]) check_evt(evt(i, 2, 9'h0), "frame_err");
                if (ov[i]) check_evt(evt(i, 3, 9'h0), "overrun");
                if (valid[i] && (!pv[i] || phs[i])) begin
                    check_evt(evt(i, 0, od[i]), "word");
                end else if (valid[i] && pv[i]) begin
                    checks++;
                    if (od[i] === pd[i]) passed++;
                    else $display("FAIL data_stable[%0d]: got %0h expected %0h", i, od[i], pd[i]);
                end
                pv[i]  <= valid[i];
                phs[i] <= valid[i] && rdy[i];
                pd[i]  <= od[i];
            end
        end
    end

    // ----------------------------------------------------------- driver
    // Builds the serial frame from the data value and drives it one bit per
    // CPB cycles. The expected outcome is queued before the first bit.
    // abort_bit >= 0 pulses reset while that frame bit is on the line.
    task automatic send_frame(input int id, input logic [8:0] d, input bit bad_par,
                              input bit bad_stop, input int abort_bit);
        int   dw;
        int   par;
        int   stops;
        int   ones;
        logic pbit;
        logic bits[$];
        dw    = data_bits(id);
        par   = (id == 1) ? 1 : ((id == 2) ? 2 : 0);
        stops = (id == 2) ? 2 : 1;
        ones  = 0;
        bits.push_back(1'b0);
        for (int i = 0; i < dw; i++) begin
            bits.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (par != 0) begin
            pbit = (par == 1) ? ((ones % 2) == 1) : ((ones % 2) == 0);
            bits.push_back(pbit ^ bad_par);
        end
        for (int s = 0; s < stops; s++) begin
            bits.push_back(!(bad_stop && s == stops - 1));
        end

        if (abort_bit < 0) begin
            if (bad_stop) exp_q.push_back(evt(id, 2, 9'h0));
            else if (bad_par && par != 0) exp_q.push_back(evt(id, 1, 9'h0));
            else if (model_full[id]) exp_q.push_back(evt(id, 3, 9'h0));
            else begin
                exp_q.push_back(evt(id, 0, d));
                model_full[id] = !rdy[id];
            end
        end

        for (int k = 0; k < bits.size(); k++) begin
            rxd[id] = bits[k];
            if (k == abort_bit) begin
                tick(2);
                rst_n = 1'b0;
                #2;
                chk("rst_mid_valid", {31'b0, valid[id]}, 32'd0);
                chk("rst_mid_data", {23'b0, od[id]}, 32'd0);
                chk("rst_mid_busy", {31'b0, busy[id]}, 32'd0);
                chk("rst_mid_flags", {29'b0, pe[id], fe[id], ov[id]}, 32'd0);
                rxd[id] = 1'b1;
                tick(1);
                rst_n = 1'b1;
                return;
            end
            tick(CPB);
        end
    endtask

    task automatic gap();
        tick($urandom_range(0, 6));
    endtask

    task automatic drain(input string name);
        tick(6 * CPB);
        chk(name, exp_q.size(), 32'd0);
    endtask

    // ----------------------------------------------------------- stimulus
    initial begin
        logic [8:0] v;
        checks = 0;
        passed = 0;
        rst_n  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rxd[i]        = 1'b1;
            rdy[i]        = 1'b1;
            model_full[i] = 1'b0;
        end

        // Reset state
        tick(3);
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            chk("reset_valid", {31'b0, valid[i]}, 32'd0);
            chk("reset_data", {23'b0, od[i]}, 32'd0);
            chk("reset_busy", {31'b0, busy[i]}, 32'd0);
            chk("reset_flags", {29'b0, pe[i], fe[i], ov[i]}, 32'd0);
        end
        tick(1);
        rst_n = 1'b1;
        tick(5);

        // 8N1: fixed patterns then random words
        send_frame(0, 9'h055, 0, 0, -1);
        send_frame(0, 9'h000, 0, 0, -1);
        send_frame(0, 9'h0FF, 0, 0, -1);
        send_frame(0, 9'h001, 0, 0, -1);
        for (int n = 0; n < 8; n++) begin
            gap();
            v = 9'($urandom_range(0, 255));
            send_frame(0, v, 0, 0, -1);
        end
        drain("drain_8n1");

        // Even parity: wrong parity then correct, then random mix
        send_frame(1, 9'h0A5, 1, 0, -1);
        send_frame(1, 9'h0A5, 0, 0, -1);
        for (int n = 0; n < 6; n++) begin
            gap();
            v = 9'($urandom_range(0, 255));
            send_frame(1, v, 1'($urandom_range(0, 1)), 0, -1);
        end
        drain("drain_even");

        // Low stop bit followed by a break
        send_frame(0, 9'h03C, 0, 1, -1);
        tick(40);
        @(negedge clk);
        chk("break_busy", {31'b0, busy[0]}, 32'd1);
        tick(1);
        rxd[0] = 1'b1;
        tick(10);
        @(negedge clk);
        chk("after_break_busy", {31'b0, busy[0]}, 32'd0);
        tick(1);
        send_frame(0, 9'h03C, 0, 0, -1);
        drain("drain_break");

        // Back-pressure and overrun
        rdy[0] = 1'b0;
        send_frame(0, 9'h011, 0, 0, -1);
        send_frame(0, 9'h022, 0, 0, -1);
        tick(8);
        @(negedge clk);
        chk("held_data", {23'b0, od[0]}, 32'h11);
        chk("held_valid", {31'b0, valid[0]}, 32'd1);
        tick(1);
        rdy[0]        = 1'b1;
        model_full[0] = 1'b0;
        tick(2);
        @(negedge clk);
        chk("accepted_valid", {31'b0, valid[0]}, 32'd0);
        tick(1);
        drain("drain_overrun");

        // One-cycle glitch on an idle line
        rxd[0] = 1'b0;
        tick(1);
        rxd[0] = 1'b1;
        tick(20);
        @(negedge clk);
        chk("glitch_busy", {31'b0, busy[0]}, 32'd0);
        tick(1);
        drain("drain_glitch");

        // Reset during data bit 3, then a clean frame
        send_frame(0, 9'h05A, 0, 0, 4);
        tick(20);
        send_frame(0, 9'h07E, 0, 0, -1);
        drain("drain_reset");

        // 5 data bits, odd parity, 2 stop bits
        send_frame(2, 9'h013, 0, 0, -1);
        for (int n = 0; n < 5; n++) begin
            gap();
            v = 9'($urandom_range(0, 31));
            send_frame(2, v, (n == 2), 0, -1);
        end
        drain("drain_5o2");

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_param.md
UART_RX_PARAM -- requirements
Module: uart_rx_param

Interface
REQ-001 SHALL have parameter DATA_W, default 8: data bits per frame, legal 5..9.
REQ-002 SHALL have parameter CLKS_PER_BIT, default 104: clk_i cycles per bit, legal >=4.
REQ-003 SHALL have parameter PARITY, default 0: 0 none, 1 even, 2 odd.
REQ-004 SHALL have parameter STOP_BITS, default 1: legal 1 or 2.
REQ-005 SHALL have port clk_i input 1: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst_ni input 1: reset, asynchronous, active-low.
REQ-007 SHALL have port rxd_i input 1: asynchronous serial line, idle high.
REQ-008 SHALL have port m_data_o output DATA_W: received word, LSB = first data bit.
REQ-009 SHALL have port m_valid_o output 1: m_data_o holds an unconsumed word.
REQ-010 SHALL have port m_ready_i input 1: consumer accepts the word when m_valid_o & m_ready_i.
REQ-011 SHALL have port parity_err_o output 1: one-cycle pulse, parity mismatch.
REQ-012 SHALL have port frame_err_o output 1: one-cycle pulse, stop bit sampled low.
REQ-013 SHALL have port overrun_o output 1: one-cycle pulse, good word dropped because the holding register was full.
REQ-014 SHALL have port busy_o output 1: high in any state other than IDLE.

Function
REQ-015 SHALL pass rxd_i through a 2-flop synchronizer reset to 1; all decisions use the synchronized value.
REQ-016 SHALL implement states IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
REQ-017 IDLE -> START on synchronized line low; bit counter loaded to sample at CLKS_PER_BIT/2 (integer division).
REQ-018 START: line high at mid-bit -> IDLE, no flags (glitch rejection); line low -> DATA.
REQ-019 DATA: sample every CLKS_PER_BIT cycles after the start mid-point; shift in LSB first; after DATA_W samples -> PARITY if PARITY!=0, else STOP.
REQ-020 PARITY: one sample; even = XOR of data and parity bit is 0; odd = XOR is 1; mismatch latched.
REQ-021 STOP: STOP_BITS samples; any low sample latches a frame error.
REQ-022 At the last stop sample: frame error -> frame_err_o pulse, word discarded, go to WAIT_HIGH; else parity error -> parity_err_o pulse, word discarded, go to IDLE; else deliver per REQ-023 and go to IDLE.
REQ-023 Delivery: if m_valid_o=0, or m_valid_o=1 with m_ready_i=1 in the same cycle, load m_data_o and keep/set m_valid_o=1 on the next edge; otherwise pulse overrun_o, drop the new word, and keep the held word unchanged.
REQ-024 m_valid_o SHALL rise on the clock edge following the cycle of the last stop-bit mid-sample (latency 1 cycle).
REQ-025 A handshake with no simultaneous delivery SHALL clear m_valid_o on the next edge; m_data_o SHALL be stable while m_valid_o=1 and not accepted.
REQ-026 WAIT_HIGH: remain until the synchronized line is high, then IDLE; a low line (break) SHALL NOT start new frames.
REQ-027 At most one of parity_err_o, frame_err_o, overrun_o SHALL be high in any cycle.
REQ-028 Sampling SHALL continue independently of m_ready_i; back-pressure never stalls reception.

Reset
REQ-029 rst_ni low SHALL asynchronously force: state IDLE, counters 0, synchronizer 1, m_data_o 0, m_valid_o 0, all pulses 0, busy_o 0.
REQ-030 Reset asserted mid-frame SHALL discard the partial word; after release, the first frame is accepted only after a new falling edge.

Verification (CLKS_PER_BIT=4 unless stated)
REQ-031 8N1, send 0x55, 0x00, 0xFF, 0x01 with m_ready_i=1 -> four m_valid_o pulses with matching data, no error pulses.
REQ-032 PARITY=1, send 0xA5 with parity bit 1 (wrong) -> parity_err_o one pulse, m_valid_o stays 0; resend with parity 0 -> 0xA5 delivered.
REQ-033 Stop bit driven low on 0x3C -> frame_err_o pulse, no delivery; line held low 40 cycles -> busy_o high, no further pulses; line high then 0x3C -> delivered.
REQ-034 m_ready_i=0, send 0x11 then 0x22 -> m_data_o=0x11 held, overrun_o pulses once; raise m_ready_i -> 0x11 accepted, m_valid_o drops.
REQ-035 Low glitch of 1 cycle on idle line -> returns to IDLE, no valid/flags; rst_ni pulsed low during data bit 3 -> all outputs 0, next full frame 0x7E received correctly.
REQ-036 DATA_W=5, PARITY=2, STOP_BITS=2, send 0x13 -> m_data_o=0x13, no errors.
